// File: rtl/data_ram_ctrl.sv
// Data RAM controller: masked write port, pipelined read port, request/ready handshake
// and a clear-sweep engine that fills the array with fillValue after reset or on request.
module data_ram_ctrl #(
    parameter int unsigned width       = 16,
    parameter int unsigned length      = 8,
    parameter int unsigned lanes       = 2,
    parameter int unsigned readLatency = 1,
    parameter logic [width-1:0] fillValue = '1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               writeEnable,
    input  logic [lanes-1:0]   laneMask,
    input  logic [length-1:0]  addr,
    input  logic [width-1:0]   writeData,
    input  logic               readEnable,
    input  logic [length-1:0]  readAddr,
    input  logic               clearReq,
    output logic               ready,
    output logic               busy,
    output logic               dataReady,
    output logic [width-1:0]   readData
);

    localparam int unsigned laneWidth = width / lanes;
    localparam int unsigned depth     = 1 << length;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    if (readLatency < 1 || readLatency > 4) begin : gBadLatency
        $error("data_ram_ctrl: readLatency must be 1..4");
    end
    if (width % lanes != 0) begin : gBadLanes
        $error("data_ram_ctrl: width must be divisible by lanes");
    end

    logic [0:0]        state, nextState;
    logic [length-1:0] sweepAddr, nextSweepAddr;
    logic              writeAccept, readAccept, sweepWrite;

    logic [width-1:0]       mem [depth];
    logic [readLatency-1:0] pipeValid;
    logic [width-1:0]       pipeData [readLatency];

    // Next-state logic; requests are only honoured while idle, sweep drops them.
    always_comb begin
        nextState     = state;
        nextSweepAddr = sweepAddr;
        writeAccept   = 1'b0;
        readAccept    = 1'b0;
        sweepWrite    = 1'b0;
        case (state)
            IDLE: begin
                writeAccept = writeEnable;
                readAccept  = readEnable;
                if (clearReq) begin
                    nextState     = SWEEP;
                    nextSweepAddr = '0;
                end
            end
            SWEEP: begin
                sweepWrite    = 1'b1;
                nextSweepAddr = sweepAddr + length'(1);
                if (sweepAddr == '1) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= SWEEP;
            sweepAddr <= '0;
            busy      <= 1'b1;
            ready     <= 1'b0;
        end else begin
            state     <= nextState;
            sweepAddr <= nextSweepAddr;
            busy      <= (nextState == SWEEP);
            ready     <= (nextState == IDLE);
        end
    end

    // Array is not reset; the sweep overwrites it. Non-blocking update gives read-first.
    always_ff @(posedge clk) begin
        if (sweepWrite) begin
            mem[sweepAddr] <= fillValue;
        end else if (writeAccept) begin
            for (int unsigned k = 0; k < lanes; k++) begin
                if (laneMask[k]) begin
                    mem[addr][k*laneWidth +: laneWidth] <= writeData[k*laneWidth +: laneWidth];
                end
            end
        end
    end

    // Stage data only loads with a valid token, so the last stage holds between reads.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pipeValid <= '0;
            for (int unsigned i = 0; i < readLatency; i++) begin
                pipeData[i] <= '0;
            end
        end else begin
            pipeValid[0] <= readAccept;
            if (readAccept) begin
                pipeData[0] <= mem[readAddr];
            end
            for (int unsigned i = 1; i < readLatency; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                if (pipeValid[i-1]) begin
                    pipeData[i] <= pipeData[i-1];
                end
            end
        end
    end

    assign dataReady = pipeValid[readLatency-1];
    assign readData  = pipeData[readLatency-1];

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Scoreboard bench for data_ram_ctrl: one instance at readLatency 1 and one at 3 share stimulus.
module tb_data_ram_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        writeEnable, readEnable, clearReq;
    logic [1:0]  laneMask;
    logic [7:0]  addr, readAddr;
    logic [15:0] writeData;

    logic        ready0, busy0, dataReady0, ready1, busy1, dataReady1;
    logic [15:0] readData0, readData1;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_ram_ctrl #(.readLatency(1)) dut0 (
        .clk(clk), .clr(clr), .writeEnable(writeEnable), .laneMask(laneMask), .addr(addr),
        .writeData(writeData), .readEnable(readEnable), .readAddr(readAddr), .clearReq(clearReq),
        .ready(ready0), .busy(busy0), .dataReady(dataReady0), .readData(readData0)
    );

    data_ram_ctrl #(.readLatency(3)) dut1 (
        .clk(clk), .clr(clr), .writeEnable(writeEnable), .laneMask(laneMask), .addr(addr),
        .writeData(writeData), .readEnable(readEnable), .readAddr(readAddr), .clearReq(clearReq),
        .ready(ready1), .busy(busy1), .dataReady(dataReady1), .readData(readData1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Pops the scoreboard for one instance; flags missed, unexpected, wrong-data and wrong-cycle reads.
    task automatic mon(input int id, input logic dr, input logic [15:0] rd);
        exp_t e;
        int   n;
        n = (id == 0) ? sb0.size() : sb1.size();
        while (n > 0 && ((id == 0) ? sb0[0].due : sb1[0].due) < cyc) begin
            e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
            checks++;
            errors++;
            $display("FAIL missedRead%0d got none want %h due %0d now %0d", id, e.data, e.due, cyc);
            n--;
        end
        if (dr) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL unexpectedRead%0d got %h want no dataReady (cycle %0d)", id, rd, cyc);
            end else begin
                e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                if (rd !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL readData%0d got %h at %0d want %h at %0d", id, rd, cyc, e.data, e.due);
                end
            end
        end
    endtask

    // Present one cycle of requests at a negedge; if the read is expected accepted, queue its result.
    task automatic step(input logic we, input logic [7:0] wa, input logic [15:0] wd, input logic [1:0] m,
                        input logic re, input logic [7:0] ra, input logic [15:0] exp, input logic cr);
        writeEnable = we; addr = wa; writeData = wd; laneMask = m;
        readEnable = re; readAddr = ra; clearReq = cr;
        if (re) begin
            sb0.push_back('{exp, cyc + 1});
            sb1.push_back('{exp, cyc + 3});
        end
        @(negedge clk);
        writeEnable = 1'b0; readEnable = 1'b0; clearReq = 1'b0; laneMask = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] m);
        step(1'b1, a, d, m, 1'b0, 8'd0, 16'd0, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp);
        step(1'b0, 8'd0, 16'd0, 2'b00, 1'b1, a, exp, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts negedges until both instances leave the sweep, optionally flooding requests meanwhile.
    task automatic waitSweep(input string nm, input logic flood);
        int n = 0;
        do begin
            writeEnable = flood; readEnable = flood; clearReq = flood;
            addr = 8'd4; readAddr = 8'd4; writeData = 16'h1234; laneMask = {2{flood}};
            @(negedge clk);
            n++;
        end while ((busy0 || busy1) && n < 1000);
        writeEnable = 1'b0; readEnable = 1'b0; clearReq = 1'b0; laneMask = '0;
        chk({nm, "Len"}, 32'(n), 32'd256);
        chk({nm, "Ready0"}, 32'(ready0), 32'd1);
        chk({nm, "Ready1"}, 32'(ready1), 32'd1);
    endtask

    task automatic chkResetOutputs(input string nm);
        chk({nm, "Busy"},  {30'd0, busy1, busy0},  32'h3);
        chk({nm, "Ready"}, {30'd0, ready1, ready0}, 32'h0);
        chk({nm, "DataReady"}, {30'd0, dataReady1, dataReady0}, 32'h0);
        chk({nm, "ReadData"}, {readData1, readData0}, 32'h0);
    endtask

    initial begin
        clr = 1'b1;
        writeEnable = 1'b0; readEnable = 1'b0; clearReq = 1'b0;
        laneMask = '0; addr = '0; readAddr = '0; writeData = '0;

        fork
            forever begin
                @(negedge clk);
                mon(0, dataReady0, readData0);
                mon(1, dataReady1, readData1);
            end
        join_none

        idle(3);
        chkResetOutputs("reset");
        clr = 1'b0;
        waitSweep("resetSweep", 1'b0);

        rd(8'd0, 16'hFFFF);
        rd(8'd128, 16'hFFFF);
        rd(8'd255, 16'hFFFF);
        idle(4);

        wr(8'd5, 16'h1234, 2'b11);
        wr(8'd5, 16'hABCD, 2'b01);
        rd(8'd5, 16'h12CD);
        wr(8'd6, 16'h5A5A, 2'b00);
        rd(8'd6, 16'hFFFF);
        idle(4);

        wr(8'd1, 16'h0011, 2'b11);
        wr(8'd2, 16'h0022, 2'b11);
        wr(8'd3, 16'h0033, 2'b11);
        rd(8'd1, 16'h0011);
        rd(8'd2, 16'h0022);
        rd(8'd3, 16'h0033);
        idle(4);

        wr(8'd9, 16'h0F0F, 2'b11);
        step(1'b1, 8'd9, 16'h5555, 2'b11, 1'b1, 8'd9, 16'h0F0F, 1'b0);
        rd(8'd9, 16'h5555);
        idle(4);

        wr(8'd4, 16'h00AA, 2'b11);
        step(1'b0, 8'd0, 16'd0, 2'b00, 1'b1, 8'd4, 16'h00AA, 1'b1);
        chk("clearBusy", {30'd0, busy1, busy0}, 32'h3);
        waitSweep("clearSweep", 1'b1);
        rd(8'd4, 16'hFFFF);
        rd(8'd9, 16'hFFFF);
        idle(4);

        step(1'b0, 8'd0, 16'd0, 2'b00, 1'b0, 8'd0, 16'd0, 1'b1);
        idle(99);
        chk("midSweepBusy", {30'd0, busy1, busy0}, 32'h3);
        #2 clr = 1'b1;
        #1 chkResetOutputs("midReset");
        idle(2);
        clr = 1'b0;
        waitSweep("restartSweep", 1'b0);
        rd(8'd4, 16'hFFFF);
        rd(8'd200, 16'hFFFF);
        idle(6);

        chk("sbEmpty", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Parametrised successor to the processor's single-port data RAM.
- Adds the following:
  - independent write and read ports on one rising clock edge;
  - per-lane write masking;
  - a configurable read pipeline latency;
  - a request/ready handshake;
  - a hardware clear-sweep engine that fills memory with a programmable value after reset or on request.
- Sits between the processor datapath/loader and memory; the processor polls busy/dataReady.

Parameters:
- width, 16, data word width in bits; must be divisible by lanes.
- length, 8, address width; depth = 2**length words.
- lanes, 2, write-mask lanes; lane width = width/lanes.
- readLatency, 1, cycles from read accept to dataReady; legal 1..4.
- fillValue, all ones (width bits), value written by the clear sweep.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  asynchronous, active-high reset.
- writeEnable  input  1  write request.
- laneMask  input  lanes  per-lane write enable; bit k covers writeData[(k+1)*width/lanes-1 : k*width/lanes].
- addr  input  length  write address.
- writeData  input  width  write data.
- readEnable  input  1  read request.
- readAddr  input  length  read address.
- clearReq  input  1  synchronous request to start a clear sweep.
- ready  output  1  high when requests are accepted (= !busy).
- busy  output  1  clear sweep in progress.
- dataReady  output  1  one-cycle pulse marking valid readData.
- readData  output  width  read result; holds last value between reads.

Behaviour:
- Reset (clr high, asynchronous):
  - state=SWEEP, sweepAddr=0, busy=1, ready=0, dataReady=0, readData=0.
  - Read pipeline valid bits cleared.
  - Memory array is not reset by clr; it is overwritten by the sweep.
- States: IDLE, SWEEP.
- SWEEP:
  - Each cycle write fillValue to all lanes of mem[sweepAddr], then sweepAddr+1.
  - On the cycle sweepAddr = 2**length-1: write it, go to IDLE, sweepAddr wraps to 0.
  - Sweep takes exactly 2**length cycles after clr deasserts.
- IDLE:
  - clearReq=1 -> SWEEP next cycle at sweepAddr 0; busy rises the cycle after clearReq sampled.
- During SWEEP:
  - writeEnable, readEnable and clearReq are ignored and dropped; no deferred action.
- Write accept (IDLE, writeEnable=1):
  - For each lane k with laneMask[k]=1, mem[addr] lane k <= writeData lane k.
  - Unmasked lanes are unchanged; laneMask=0 is a legal no-op.
- Read accept (IDLE, readEnable=1):
  - mem[readAddr] is sampled at the accept edge.
  - Result enters a readLatency-deep valid/data shift pipeline.
  - readData updates and dataReady=1 exactly readLatency cycles after the accept edge.
  - Back-to-back reads are accepted every cycle; throughput is 1 per cycle.
- Simultaneous read and write in the same cycle, any addresses: both accepted.
  - Same address: read-first; the read returns pre-write contents.
- Clear requested with reads in flight:
  - Reads already in the pipeline complete normally with their captured data.
- clearReq and writeEnable in the same IDLE cycle:
  - The write is performed, then the sweep starts next cycle (and overwrites it).
- dataReady is low in every cycle without a completing read.
  - readData holds its previous value in those cycles.
- clr asserted mid-sweep or mid-read: immediately returns to reset values; the sweep restarts at 0 after release.
- Address arithmetic: sweepAddr is length bits, modulo 2**length; no out-of-range addresses exist.

Test Plan:
- Reset sweep (defaults): release clr -> busy=1 for exactly 256 cycles, then ready=1; reading addresses 0, 128 and 255 returns 16'hFFFF with dataReady one cycle after accept.
- Lane masking: write addr 5 = 16'h1234 with mask 2'b11, then write 16'hABCD with mask 2'b01 -> read addr 5 returns 16'h12CD.
- Latency: readLatency=3; reads of addr 1, 2, 3 on consecutive cycles after writing 16'h0011/16'h0022/16'h0033 -> dataReady high for three consecutive cycles starting 3 cycles after the first accept, data in order.
- Read-during-write: addr 9 holds 16'h0F0F; same cycle write 16'h5555 to 9 and read 9 -> returns 16'h0F0F; next read returns 16'h5555.
- Clear mid-operation: read of addr 4 (16'h00AA) accepted in the same cycle as clearReq -> 16'h00AA still delivered; requests during the following 256 busy cycles are dropped; afterwards addr 4 reads 16'hFFFF.
- Reset mid-sweep: assert clr at sweep cycle 100 for 2 cycles -> outputs return to reset values at once; the sweep restarts and busy lasts a further 256 cycles from release.
